axi_uart_tx_fifo: RTL and testbench
===================================

Name: axi_uart_tx_fifo

Overview:
AXI-Lite slave UART transmitter with a parametrised TX FIFO, a programmable baud divider and a real 8N1 serial output. Software pushes bytes into the FIFO through the TXDATA register and polls STATUS or waits for the optional interrupt. The serialiser drains the FIFO back-to-back onto uart_txd. The block sits on the peripheral AXI-Lite bus beside the other memory-mapped slaves.

Parameters:
ADDR_WIDTH, 4, AXI-Lite address width; only addr[3:0] is decoded.
DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
FIFO_DEPTH, 16, TX FIFO entries; must be a power of two, 2..128.
BAUD_DIV_RST, 867, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  4  write byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
uart_txd  out  1  serial output, idle high
tx_busy  out  1  high while the serialiser is not in IDLE

Behaviour:
- Reset values:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0.
  - uart_txd = 1; tx_busy = 0.
  - FIFO is empty; BAUDDIV = BAUD_DIV_RST.
- Register map:
  - 0x0 TXDATA (write-only): a write with WSTRB[0]=1 pushes WDATA[7:0]. A read returns 0 with OKAY.
  - 0x4 STATUS (read-only): [0] fifo_full; [1] fifo_empty; [2] tx_busy; [15:8] fill level (count, 0..FIFO_DEPTH); other bits 0. Writes are ignored and respond OKAY.
  - 0x8 BAUDDIV (read/write, 16 bits in [15:0]): WSTRB[0] and WSTRB[1] gate the low and high byte.
  - 0xC: reserved, or IRQ_EN when the optional feature is compiled in.
  - Any other address: read returns 0 with SLVERR (2'b10); write responds SLVERR with no effect.
- Write handshake:
  - Accepted only when AWVALID and WVALID are both high and BVALID is 0.
  - AWREADY and WREADY pulse high together for exactly 1 cycle.
  - The register effect and BVALID=1 occur on the next edge.
  - BVALID holds until BREADY is sampled high.
- Full FIFO:
  - A TXDATA write while the FIFO is full drops the byte and responds SLVERR.
  - "Full" is evaluated before any same-cycle pop, so a simultaneous pop does not make room.
- Read handshake:
  - Accepted when ARVALID is high and RVALID is 0.
  - ARREADY pulses for 1 cycle; RDATA and RVALID follow on the next edge.
  - RDATA is held stable until RREADY is sampled high.
- Reads and writes are independent and may complete in the same cycle. A STATUS read reflects state before that cycle's push.
- Serialiser FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop one byte, latch the divider value, go to START.
  - START: uart_txd=0 for one bit period.
  - DATA: 8 bits LSB first, one bit period each; a 3-bit index counts 0..7.
  - STOP: uart_txd=1 for one bit period. At the end of STOP, go to IDLE; IDLE pops in the following cycle, giving a 1-clock idle gap between frames.
  - Bit period is BAUDDIV+1 clocks, counted by a 16-bit down-counter. BAUDDIV=0 gives 1 clock per bit.
  - BAUDDIV writes during a frame take effect at the next frame start.
- FIFO: circular, with log2(FIFO_DEPTH)-bit pointers that wrap at FIFO_DEPTH and a separate count. Push and pop in the same cycle leave the count unchanged.
- Reset mid-frame: uart_txd returns to 1 immediately (asynchronously), the FIFO empties and the FSM returns to IDLE.

Optional Feature:
- Macro: AXI_UART_TX_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, reset 0) and register 0xC IRQ_EN, read/write: [0] empty_ie, [1] done_ie; reset 0.
  - irq is registered: irq = (empty_ie & fifo_empty) | (done_ie & fifo_empty & ~tx_busy).
- When undefined: no irq port; 0xC behaves as an unmapped address (SLVERR).

Test Plan:
- Reset, then read 0x4 -> RDATA=0x0000_0002, RRESP=OKAY; read 0x8 -> 0x0000_0363; uart_txd=1.
- Write BAUDDIV=3, then TXDATA=0xA5 -> uart_txd gives start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 clocks; tx_busy high for 40 clocks.
- With BAUDDIV=0xFFFF, push FIFO_DEPTH+1 bytes quickly -> the first FIFO_DEPTH+1 writes are OKAY (one byte has already popped into the serialiser). Then STATUS[0]=1 and a further write returns BRESP=SLVERR with the byte lost.
- Hold BREADY low after a write -> BVALID stays 1 and a second AW/W is not accepted; raise BREADY -> the second write completes.
- Read 0x6 -> RRESP=SLVERR, RDATA=0. Assert rst_n low mid-DATA-bit -> uart_txd=1 at once; STATUS=0x2 after release.
- AXI_UART_TX_IRQ_EN defined: write IRQ_EN=2, push 1 byte -> irq drops to 0 during the frame and rises 1 clock after STOP completes.

Source files
------------

// File: rtl/axi_uart_tx_fifo.sv
// axi_uart_tx_fifo
//   AXI-Lite slave UART transmitter. Bytes written to TXDATA are queued in a
//   circular TX FIFO and shifted out as 8N1 frames on uart_txd. The bit
//   period is BAUDDIV+1 clocks.
//
// Register map (addr[3:0]):
//   0x0 TXDATA  W   push WDATA[7:0] when WSTRB[0]; SLVERR when FIFO is full
//   0x4 STATUS  R   [0] full, [1] empty, [2] tx_busy, [15:8] fill level
//   0x8 BAUDDIV RW  [15:0], byte-gated by WSTRB[1:0]
//   0xC IRQ_EN  RW  [0] empty_ie, [1] done_ie (only with AXI_UART_TX_IRQ_EN)
//   other       -   SLVERR, read data 0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   S_AXI_*             AXI-Lite slave (AW, W, B, AR, R channels)
//   uart_txd            serial output, idle high
//   tx_busy             serialiser not idle
//   irq                 registered interrupt (only with AXI_UART_TX_IRQ_EN)
//
// Optional feature macro: AXI_UART_TX_IRQ_EN
//
// Serialiser states:
//   state   | meaning
//   S_IDLE  | line high; pop a byte when FIFO is non-empty
//   S_START | start bit (low) for one bit period
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (high) for one bit period
module axi_uart_tx_fifo #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 867
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  uart_txd,
  output logic                  tx_busy
`ifdef AXI_UART_TX_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_full, fifo_empty;
  logic [15:0]           baud_div;

  logic                  wr_fire, rd_fire, push, pop;
  logic [1:0]            wr_resp, rd_resp;
  logic [1:0]            baud_we;
  logic [DATA_WIDTH-1:0] rd_data;

  state_t                state;
  logic [15:0]           bit_cnt;
  logic [15:0]           div_latched;
  logic [7:0]            shift;
  logic [2:0]            idx;

`ifdef AXI_UART_TX_IRQ_EN
  logic [1:0]            irq_en;
  logic                  irq_en_we;
`endif

  // Address/data bits beyond the decoded fields are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign rd_fire    = S_AXI_ARREADY & S_AXI_ARVALID;

  // Write decode. Full is taken from the registered count, so a pop in the
  // same cycle does not make room for this write.
  always_comb begin
    wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
    wr_resp = RESP_OKAY;
    push    = 1'b0;
    baud_we = 2'b00;
`ifdef AXI_UART_TX_IRQ_EN
    irq_en_we = 1'b0;
`endif
    case (S_AXI_AWADDR[3:0])
      4'h0: begin
        if (S_AXI_WSTRB[0]) begin
          if (fifo_full) wr_resp = RESP_SLVERR;
          else           push    = wr_fire;
        end
      end
      4'h4: wr_resp = RESP_OKAY;
      4'h8: baud_we = S_AXI_WSTRB[1:0] & {2{wr_fire}};
`ifdef AXI_UART_TX_IRQ_EN
      4'hC: irq_en_we = wr_fire & S_AXI_WSTRB[0];
`endif
      default: wr_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (S_AXI_ARADDR[3:0])
      4'h0: rd_data = '0;
      4'h4: begin
        rd_data[0]      = fifo_full;
        rd_data[1]      = fifo_empty;
        rd_data[2]      = tx_busy;
        rd_data[8 +: CW] = count;
      end
      4'h8: rd_data[15:0] = baud_div;
`ifdef AXI_UART_TX_IRQ_EN
      4'hC: rd_data[1:0] = irq_en;
`endif
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  // Write channel: AWREADY/WREADY are a one-cycle pulse; the register
  // effect and BVALID land on the edge that completes the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      baud_div      <= 16'(BAUD_DIV_RST);
`ifdef AXI_UART_TX_IRQ_EN
      irq_en        <= 2'b00;
`endif
    end else begin
      if (!S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID) begin
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end else begin
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY  <= 1'b0;
      end
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_resp;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      if (baud_we[0]) baud_div[7:0]  <= S_AXI_WDATA[7:0];
      if (baud_we[1]) baud_div[15:8] <= S_AXI_WDATA[15:8];
`ifdef AXI_UART_TX_IRQ_EN
      if (irq_en_we) irq_en <= S_AXI_WDATA[1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && !S_AXI_RVALID && S_AXI_ARVALID;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= S_AXI_WDATA[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Divider is latched at the pop so BAUDDIV writes mid-frame only affect
  // the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      bit_cnt     <= '0;
      div_latched <= '0;
      shift       <= '0;
      idx         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          if (pop) begin
            shift       <= mem[rd_ptr];
            div_latched <= baud_div;
            bit_cnt     <= baud_div;
            uart_txd    <= 1'b0;
            tx_busy     <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          if (bit_cnt == '0) begin
            bit_cnt  <= div_latched;
            uart_txd <= shift[0];
            shift    <= shift >> 1;
            idx      <= '0;
            state    <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_latched;
            if (idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= S_STOP;
            end else begin
              uart_txd <= shift[0];
              shift    <= shift >> 1;
              idx      <= idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_cnt == '0) begin
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (irq_en[0] & fifo_empty) | (irq_en[1] & fifo_empty & ~tx_busy);
  end
`endif

endmodule

// File: tb/tb_axi_uart_tx_fifo.sv
// Testbench for axi_uart_tx_fifo: directed AXI-Lite stimulus with a byte
// scoreboard; a line monitor decodes uart_txd frames and checks them
// against the queued bytes cycle by cycle.
module tb_axi_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        uart_txd;
  logic        tx_busy;
`ifdef AXI_UART_TX_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_period = 4;
  bit mon_en = 1'b0;
  bit in_frame = 1'b0;
  int frames_seen = 0;
  int last_idle = -1;
  int end_cyc = 0;
  logic [7:0] sb_q[$];

  axi_uart_tx_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(867)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .uart_txd(uart_txd), .tx_busy(tx_busy)
`ifdef AXI_UART_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_handshake", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("ar_handshake", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_seen", {31'd0, rvalid}, 32'd1);
    data = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while ((in_frame || sb_q.size() != 0 || tx_busy !== 1'b0) && n < 3000);
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  // Line monitor: each frame is compared cycle by cycle against the byte at
  // the head of the scoreboard, using the bit period in force at frame start.
  initial begin : uart_monitor
    logic [7:0] exp_b, rx;
    logic eb;
    int p, errs, bi;
    bit aborted;
    forever begin
      @(posedge clk); #1;
      if (mon_en && rst_n === 1'b1 && uart_txd === 1'b0) begin
        in_frame = 1'b1;
        p = exp_period;
        last_idle = cyc - end_cyc - 1;
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", 32'(sb_q.size()), 32'd1);
          exp_b = 8'h00;
        end else begin
          exp_b = sb_q.pop_front();
        end
        errs = 0; rx = '0; aborted = 1'b0;
        for (int c = 0; c < 10 * p; c++) begin
          if (c > 0) begin @(posedge clk); #1; end
          if (rst_n !== 1'b1 || !mon_en) begin aborted = 1'b1; break; end
          bi = c / p;
          if (bi == 0)      eb = 1'b0;
          else if (bi == 9) eb = 1'b1;
          else              eb = exp_b[bi-1];
          if (uart_txd !== eb || tx_busy !== 1'b1) errs++;
          if (bi >= 1 && bi <= 8 && (c % p) == p / 2) rx[bi-1] = uart_txd;
        end
        if (!aborted) begin
          end_cyc = cyc;
          chk("frame_wave", 32'(errs), 32'd0);
          chk("frame_byte", 32'(rx), 32'(exp_b));
          frames_seen++;
          @(posedge clk); #1;
          chk("post_frame", {30'd0, uart_txd, tx_busy}, 32'h2);
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  r;
    int viol, n;

    #12;
    chk("rst_line", {30'd0, uart_txd, tx_busy}, 32'h2);
    chk("rst_axi_valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    axi_read(4'h4, d, r);
    chk("status_rst", d, 32'h2);
    chk("status_rst_resp", 32'(r), 32'd0);
    axi_read(4'h8, d, r);
    chk("baud_rst", d, 32'h363);
    chk("txd_idle", {31'd0, uart_txd}, 32'd1);

    // Single frame at 4 clocks per bit.
    mon_en = 1'b1;
    axi_write(4'h8, 32'd3, 4'hF, r);
    chk("baud_wr_resp", 32'(r), 32'd0);
    exp_period = 4;
    sb_q.push_back(8'hA5);
    axi_write(4'h0, 32'hA5, 4'h1, r);
    chk("tx_a5_resp", 32'(r), 32'd0);
    wait_idle("idle_a5");
    chk("frames_1", 32'(frames_seen), 32'd1);

    // Back-to-back frames: fill level while one byte waits, 1-clock gap.
    sb_q.push_back(8'h3C);
    axi_write(4'h0, 32'h3C, 4'h1, r);
    sb_q.push_back(8'h81);
    axi_write(4'h0, 32'h81, 4'h1, r);
    axi_read(4'h4, d, r);
    chk("status_one_queued", d, 32'h0104);
    wait_idle("idle_pair");
    chk("frames_3", 32'(frames_seen), 32'd3);
    chk("idle_gap", 32'(last_idle), 32'd1);

    // BAUDDIV change mid-frame applies to the next frame only.
    sb_q.push_back(8'h5A);
    axi_write(4'h0, 32'h5A, 4'h1, r);
    axi_write(4'h8, 32'd1, 4'h3, r);
    exp_period = 2;
    sb_q.push_back(8'hC3);
    axi_write(4'h0, 32'hC3, 4'h1, r);
    wait_idle("idle_baudchg");
    chk("frames_5", 32'(frames_seen), 32'd5);

    // BREADY held low blocks the next write; reads still proceed.
    bready = 1'b0;
    axi_write(4'h8, 32'd5, 4'hF, r);
    chk("bvalid_held", {31'd0, bvalid}, 32'd1);
    awaddr = 4'h8; wdata = 32'd2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    viol = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) viol++;
    end
    chk("bready_block", 32'(viol), 32'd0);
    axi_read(4'h8, d, r);
    chk("baud_first_write", d, 32'd5);
    bready = 1'b1;
    axi_write(4'h8, 32'd2, 4'hF, r);
    chk("second_write_resp", 32'(r), 32'd0);
    axi_read(4'h8, d, r);
    chk("baud_second_write", d, 32'd2);

    // Decode corners.
    axi_read(4'h6, d, r);
    chk("rd6_data", d, 32'd0);
    chk("rd6_resp", 32'(r), 32'd2);
    axi_read(4'h0, d, r);
    chk("rd_txdata", {d[29:0], r}, 32'd0);
    axi_read(4'hC, d, r);
`ifdef AXI_UART_TX_IRQ_EN
    chk("rdC_resp", 32'(r), 32'd0);
`else
    chk("rdC_resp", 32'(r), 32'd2);
    axi_write(4'hC, 32'd3, 4'hF, r);
    chk("wrC_resp", 32'(r), 32'd2);
`endif
    chk("rdC_data", d, 32'd0);
    axi_write(4'h6, 32'hFF, 4'hF, r);
    chk("wr6_resp", 32'(r), 32'd2);
    axi_write(4'h4, 32'hFFFF, 4'hF, r);
    chk("wr_status_resp", 32'(r), 32'd0);
    axi_write(4'h8, 32'h1234_ABCD, 4'b0010, r);
    axi_read(4'h8, d, r);
    chk("baud_strobe_hi", d, 32'hAB02);
    axi_write(4'h0, 32'h77, 4'b1110, r);
    chk("tx_nostrb_resp", 32'(r), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    axi_read(4'h4, d, r);
    chk("tx_nostrb_status", d, 32'h2);

    // Fill the FIFO behind a very slow frame.
    mon_en = 1'b0;
    axi_write(4'h8, 32'hFFFF, 4'h3, r);
    viol = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      axi_write(4'h0, 32'(i), 4'h1, r);
      if (r !== 2'b00) viol++;
    end
    chk("fill_resp", 32'(viol), 32'd0);
    axi_read(4'h4, d, r);
    chk("status_full", d, 32'((DEPTH << 8) | 5));
    axi_write(4'h0, 32'hEE, 4'h1, r);
    chk("full_resp", 32'(r), 32'd2);
    axi_read(4'h4, d, r);
    chk("status_full_after", d, 32'((DEPTH << 8) | 5));

    rst_n = 1'b0;
    #2;
    chk("rst_full_line", {30'd0, uart_txd, tx_busy}, 32'h2);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h4, d, r);
    chk("status_after_rst", d, 32'h2);

    // Reset in the middle of a data bit.
    axi_write(4'h8, 32'd9, 4'h3, r);
    axi_write(4'h0, 32'h00, 4'h1, r);
    repeat (14) @(posedge clk);
    #5;
    chk("pre_rst_data_bit", {30'd0, uart_txd, tx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_line", {30'd0, uart_txd, tx_busy}, 32'h2);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h4, d, r);
    chk("status_mid_rst", d, 32'h2);
    axi_read(4'h8, d, r);
    chk("baud_mid_rst", d, 32'h363);

`ifdef AXI_UART_TX_IRQ_EN
    chk("irq_rst", {31'd0, irq}, 32'd0);
    axi_write(4'hC, 32'd2, 4'h1, r);
    chk("irq_en_resp", 32'(r), 32'd0);
    axi_read(4'hC, d, r);
    chk("irq_en_rd", d, 32'd2);
    chk("irq_idle", {31'd0, irq}, 32'd1);
    axi_write(4'h8, 32'd3, 4'h3, r);
    exp_period = 4;
    mon_en = 1'b1;
    sb_q.push_back(8'h11);
    axi_write(4'h0, 32'h11, 4'h1, r);
    chk("irq_frame", {31'd0, irq}, 32'd0);
    n = 0;
    while (tx_busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("irq_busy_fall", {31'd0, tx_busy}, 32'd0);
    chk("irq_at_stop_end", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wait_idle("idle_irq");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
